// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the simpleCPU data memory: FSM encoding and default geometry.
package cpu_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } mem_state_t;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 6;
  localparam int unsigned MEM_DEPTH  = 4;

endpackage : cpu_mem_pkg

// File: rtl/cpu_ram_sync.sv
// Synchronous data memory for the simpleCPU datapath: registered read with valid strobe,
// out-of-range error pulse, and a self-initialising sweep (word i <- i) after reset or clear.
module cpu_ram_sync
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_n,
  input  logic              rd,
  input  logic              wr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  generate
    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
      $error("cpu_ram_sync: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_d;
  logic              dout_valid_d;
  logic              busy_d;
  logic              err_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  logic              in_range;
  logic [IDX_W-1:0]  req_idx;

  // Wide compare so DEPTH == 2**ADDR_W is representable.
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign req_idx  = IDX_W'(addr);

  // Next-state, next-output and memory write-port decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    busy_d       = busy;
    mem_we       = 1'b0;
    mem_widx     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_widx  = IDX_W'(cnt_q);
        mem_wdata = DATA_W'(cnt_q);
        cnt_d     = cnt_q + 1'b1;
        // Exit on the last implemented word so a full-size array never wraps.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_IDLE: begin
        if (!ena_n) begin
          if (clr) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else if (rd) begin
            // A simultaneous write is dropped silently.
            if (in_range) begin
              dout_d       = mem[req_idx];
              dout_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (wr) begin
            if (in_range) begin
              mem_we    = 1'b1;
              mem_widx  = req_idx;
              mem_wdata = din;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

  // Storage array; no reset, contents come from the init sweep.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule : cpu_ram_sync

// File: tb/tb_cpu_ram_sync.sv
// Directed plus randomized check of cpu_ram_sync against a cycle-level behavioural model.
module tb_cpu_ram_sync;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              ena_n;
  logic              rd;
  logic              wr;
  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  cpu_ram_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena_n     (ena_n),
    .rd        (rd),
    .wr        (wr),
    .clr       (clr),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                busy_left = 0;
  logic [DATA_W-1:0] exp_dout  = '0;
  logic              exp_valid = 1'b0;
  logic              exp_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = DATA_W'(i);
  endtask

  // One clock cycle: drive inputs, advance model, clock, compare all outputs.
  task automatic step(input logic r, input logic en_n, input logic rd_i, input logic wr_i,
                      input logic clr_i, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input string tag);
    rst = r; ena_n = en_n; rd = rd_i; wr = wr_i; clr = clr_i; addr = a; din = d;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      busy_left = DEPTH;
      exp_dout  = '0;
      model_fill();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (!en_n) begin
      if (clr_i) begin
        busy_left = DEPTH;
        model_fill();
      end else if (rd_i) begin
        if (int'(a) < int'(DEPTH)) begin
          exp_dout  = ref_mem[int'(a)];
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end else if (wr_i) begin
        if (int'(a) < int'(DEPTH)) ref_mem[int'(a)] = d;
        else exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".dout"},  32'(dout),       32'(exp_dout));
    check({tag, ".valid"}, 32'(dout_valid), 32'(exp_valid));
    check({tag, ".err"},   32'(err),        32'(exp_err));
    check({tag, ".busy"},  32'(busy),       32'(busy_left > 0));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, tag);
  endtask

  task automatic read(input logic [ADDR_W-1:0] a, input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, '0, tag);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, d, tag);
  endtask

  // Count cycles busy stays high, bounded so a stuck DUT still terminates.
  task automatic count_busy(input int want, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      idle(tag);
    end
    check({tag, ".len"}, 32'(n), 32'(want));
  endtask

  initial begin
    rst = 1'b0; ena_n = 1'b1; rd = 1'b0; wr = 1'b0; clr = 1'b0; addr = '0; din = '0;
    #2;

    // 1. Reset, sweep length, initial contents
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "reset");
    count_busy(DEPTH, "sweep");
    for (int i = 0; i < int'(DEPTH); i++) begin
      read(ADDR_W'(i), "init_rd");
      check("init_val", 32'(dout), 32'(i));
    end

    // 2. Write then read back
    write(6'd3, 8'hA5, "wr3");
    read(6'd3, "rd3");
    check("rd3_val", 32'(dout), 32'hA5);
    read(6'd2, "rd2");

    // 3. Out-of-range read and write
    read(6'd5, "rd_oor");
    write(6'd6, 8'hFF, "wr_oor");
    for (int i = 0; i < int'(DEPTH); i++) read(ADDR_W'(i), "oor_chk");

    // 4. Simultaneous rd/wr
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 8'h77, "rdwr");
    check("rdwr_val", 32'(dout), 32'h01);
    read(6'd1, "rdwr_after");

    // 5. Disabled accesses, clear, read during busy
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, "dis_rd");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 8'hEE, "dis_wr");
    read(6'd0, "dis_chk");
    write(6'd0, 8'h55, "wr55");
    read(6'd0, "rd55");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 8'h00, "clr");
    read(6'd0, "busy_rd");
    count_busy(DEPTH - 1, "clr_sweep");
    read(6'd0, "post_clr");
    check("post_clr_val", 32'(dout), 32'h00);
    read(6'd3, "post_clr3");

    // 6. Reset mid-sweep at cnt=2
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "rst_a");
    idle("mid1");
    idle("mid2");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, '0, "rst_mid");
    count_busy(DEPTH, "resweep");

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 24) == 0),
           ADDR_W'($urandom_range(0, 7)),
           DATA_W'($urandom),
           "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpu_ram_sync
